// File: rtl/random_arbiter.sv
// -----------------------------------------------------------------------------
// random_arbiter
//
// Shares one 8-bit LFSR random generator among NREQ requesters. Requesters are
// served round-robin. For each grant the generator is stepped STEP_CYCLES
// times and one byte is sampled. The byte is range-limited by rejection
// sampling against the requester's inclusive upper bound. After MAX_RETRY
// rejections the result is clamped to that bound.
//
// Ports:
//   clk          clock
//   rst          synchronous, active-high reset
//   req          per-requester request level, held until ack
//   req_max      per-requester inclusive upper bound, requester i at [8i+7:8i]
//   ack          one-hot, single-cycle completion pulse
//   rsp_data     result byte, valid while ack != 0
//   rsp_clamped  result was clamped, valid while ack != 0
//   grant        one-hot owner of the current draw, 0 when idle
//   busy         high in every state except IDLE
//   gen_ena      generator shift enable
//   gen_start    generator start, always equal to gen_ena
//   gen_value    generator output byte
// -----------------------------------------------------------------------------
module random_arbiter #(
  parameter int NREQ        = 4,
  parameter int STEP_CYCLES = 4,
  parameter int MAX_RETRY   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_max,
  output logic [NREQ-1:0]   ack,
  output logic [7:0]        rsp_data,
  output logic              rsp_clamped,
  output logic [NREQ-1:0]   grant,
  output logic              busy,
  output logic              gen_ena,
  output logic              gen_start,
  input  logic [7:0]        gen_value
);

  localparam int              IDX_W      = $clog2(NREQ);
  localparam logic [IDX_W-1:0] LAST_RST  = IDX_W'(NREQ - 1);
  localparam logic [3:0]      STEP_LOAD  = 4'(STEP_CYCLES - 1);
  localparam logic [3:0]      RETRY_LAST = 4'(MAX_RETRY - 1);

  typedef enum logic [1:0] {
    IDLE,
    STEP,
    CHECK,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [7:0]       max_q, max_d;
  logic [7:0]       result_q, result_d;
  logic             clamped_q, clamped_d;
  logic [3:0]       retry_q, retry_d;
  logic [3:0]       step_q, step_d;

  // Round-robin pick: first requester with req set, starting just after last.
  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0] cand_idx;
  logic [7:0]       pick_max;
  int               cand;

  // NOTE: every variable written in always_comb gets a default first; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    cand_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand     = (int'(last_q) + k) % NREQ;
      cand_idx = IDX_W'(cand);
      if (!pick_found && req[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  assign pick_max = req_max[{pick_idx, 3'b000} +: 8];

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    last_d    = last_q;
    max_d     = max_q;
    result_d  = result_q;
    clamped_d = clamped_q;
    retry_d   = retry_q;
    step_d    = step_q;

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          idx_d   = pick_idx;
          max_d   = pick_max;
          retry_d = '0;
          // The LFSR never produces 0, so a zero bound is answered directly.
          if (pick_max == 8'h00) begin
            result_d  = 8'h00;
            clamped_d = 1'b0;
            state_d   = DONE;
          end else begin
            step_d  = STEP_LOAD;
            state_d = STEP;
          end
        end
      end

      STEP: begin
        if (step_q == 4'd0) begin
          state_d = CHECK;
        end else begin
          step_d = step_q - 4'd1;
        end
      end

      CHECK: begin
        if (gen_value <= max_q) begin
          result_d  = gen_value;
          clamped_d = 1'b0;
          state_d   = DONE;
        end else begin
          retry_d = retry_q + 4'd1;
          if (retry_q == RETRY_LAST) begin
            result_d  = max_q;
            clamped_d = 1'b1;
            state_d   = DONE;
          end else begin
            step_d  = STEP_LOAD;
            state_d = STEP;
          end
        end
      end

      DONE: begin
        last_d  = idx_q;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its inputs regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      last_q    <= LAST_RST;
      max_q     <= '0;
      result_q  <= '0;
      clamped_q <= 1'b0;
      retry_q   <= '0;
      step_q    <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
      max_q     <= max_d;
      result_q  <= result_d;
      clamped_q <= clamped_d;
      retry_q   <= retry_d;
      step_q    <= step_d;
    end
  end

  logic [NREQ-1:0] idx_onehot;
  logic            done;

  assign idx_onehot  = NREQ'(1) << idx_q;
  assign done        = (state_q == DONE);
  assign busy        = (state_q != IDLE);
  assign grant       = busy ? idx_onehot : '0;
  assign ack         = done ? idx_onehot : '0;
  assign rsp_data    = done ? result_q : 8'h00;
  assign rsp_clamped = done & clamped_q;
  assign gen_ena     = (state_q == STEP);
  assign gen_start   = gen_ena;

endmodule

// File: tb/tb_random_arbiter.sv
// -----------------------------------------------------------------------------
// tb_random_arbiter
//
// Self-checking bench for random_arbiter. Models the external 8-bit LFSR
// generator (seed 0xAD, x^8+x^6+x^5+x^4+1, left shift) and predicts each draw
// from the arbitration and rejection-sampling rules: winner, result, clamp
// flag, ack latency and number of generator shifts.
// -----------------------------------------------------------------------------
module tb_random_arbiter;

  localparam int NREQ = 4;
  localparam int STEP = 4;
  localparam int MAXR = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic            gen_rst;

  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] req_max;
  logic [NREQ-1:0]   ack;
  logic [7:0]        rsp_data;
  logic              rsp_clamped;
  logic [NREQ-1:0]   grant;
  logic              busy;
  logic              gen_ena;
  logic              gen_start;
  logic [7:0]        g1_q;

  logic [NREQ-1:0]   r2_req;
  logic [8*NREQ-1:0] r2_req_max;
  logic [NREQ-1:0]   r2_ack;
  logic [7:0]        r2_rsp_data;
  logic              r2_rsp_clamped;
  logic [NREQ-1:0]   r2_grant;
  logic              r2_busy;
  logic              r2_gen_ena;
  logic              r2_gen_start;
  logic [7:0]        g2_q;

  random_arbiter #(.NREQ(NREQ), .STEP_CYCLES(STEP), .MAX_RETRY(MAXR)) dut (
    .clk(clk), .rst(rst), .req(req), .req_max(req_max), .ack(ack),
    .rsp_data(rsp_data), .rsp_clamped(rsp_clamped), .grant(grant), .busy(busy),
    .gen_ena(gen_ena), .gen_start(gen_start), .gen_value(g1_q)
  );

  random_arbiter #(.NREQ(NREQ), .STEP_CYCLES(STEP), .MAX_RETRY(2)) dut_r2 (
    .clk(clk), .rst(rst), .req(r2_req), .req_max(r2_req_max), .ack(r2_ack),
    .rsp_data(r2_rsp_data), .rsp_clamped(r2_rsp_clamped), .grant(r2_grant),
    .busy(r2_busy), .gen_ena(r2_gen_ena), .gen_start(r2_gen_start),
    .gen_value(g2_q)
  );

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  // External generator models, one per arbiter instance.
  always @(posedge clk) begin
    if (gen_rst) begin
      g1_q <= 8'hAD;
      g2_q <= 8'hAD;
    end else begin
      if (gen_ena && gen_start)       g1_q <= lfsr_next(g1_q);
      if (r2_gen_ena && r2_gen_start) g2_q <= lfsr_next(g2_q);
    end
  end

  int start_bad = 0;
  always @(negedge clk) begin
    if (gen_start !== gen_ena || r2_gen_start !== r2_gen_ena) start_bad <= start_bad + 1;
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference state: generator value, round-robin pointer, and whether the
  // DUT currently sits in its DONE cycle (adds one IDLE cycle to latency).
  logic [7:0] m_gen;
  int         m_last;
  bit         from_done;

  task automatic fresh_reset();
    @(negedge clk);
    rst        = 1'b1;
    gen_rst    = 1'b1;
    req        = '0;
    req_max    = '0;
    r2_req     = '0;
    r2_req_max = '0;
    repeat (2) @(negedge clk);
    rst       = 1'b0;
    gen_rst   = 1'b0;
    m_gen     = 8'hAD;
    m_last    = NREQ - 1;
    from_done = 1'b0;
  endtask

  task automatic draw(input string tag, input logic [NREQ-1:0] r,
                      input logic [8*NREQ-1:0] m, input bit drop,
                      output logic [7:0] obs_data, output logic [NREQ-1:0] obs_ack);
    int         w;
    int         c;
    int         draws;
    int         lat;
    int         n;
    int         ena_cnt;
    bit         fin;
    logic [7:0] mx;
    logic [7:0] g;
    logic [7:0] ev;
    logic       ec;
    logic       got_cl;

    w = 0;
    fin = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      c = (m_last + k) % NREQ;
      if (!fin && ((r >> c) & 4'b0001) != 4'b0000) begin
        w   = c;
        fin = 1'b1;
      end
    end

    mx    = 8'(m >> (8 * w));
    g     = m_gen;
    draws = 0;
    ev    = 8'h00;
    ec    = 1'b0;
    fin   = 1'b0;
    if (mx != 8'h00) begin
      while (!fin) begin
        for (int s = 0; s < STEP; s++) g = lfsr_next(g);
        draws++;
        if (g <= mx) begin
          ev  = g;
          fin = 1'b1;
        end else if (draws == MAXR) begin
          ev  = mx;
          ec  = 1'b1;
          fin = 1'b1;
        end
      end
    end
    lat = (mx == 8'h00) ? 1 : (STEP + 1) * draws + 1;
    if (from_done) lat++;

    req     = r;
    req_max = m;

    n       = 0;
    ena_cnt = 0;
    obs_ack = '0;
    obs_data = 8'h00;
    got_cl  = 1'b0;
    while (obs_ack == '0 && n < 200) begin
      @(posedge clk);
      @(negedge clk);
      n++;
      if (gen_ena) ena_cnt++;
      obs_ack  = ack;
      obs_data = rsp_data;
      got_cl   = rsp_clamped;
      if (drop && n == 2) begin
        req     = '0;
        req_max = $urandom();
      end
    end

    check({tag, "_ack"},     32'(obs_ack),  32'(NREQ'(1) << w));
    check({tag, "_data"},    32'(obs_data), 32'(ev));
    check({tag, "_clamped"}, 32'(got_cl),   32'(ec));
    check({tag, "_latency"}, 32'(n),        32'(lat));
    check({tag, "_shifts"},  32'(ena_cnt),  32'(STEP * draws));

    m_gen     = g;
    m_last    = w;
    from_done = 1'b1;
  endtask

  logic [7:0]      d;
  logic [NREQ-1:0] a;
  logic [NREQ-1:0] seen;
  logic [NREQ-1:0] rr;
  logic [8*NREQ-1:0] rm;
  int n;
  int ena_cnt;

  initial begin
    rst        = 1'b1;
    gen_rst    = 1'b1;
    req        = '0;
    req_max    = '0;
    r2_req     = '0;
    r2_req_max = '0;

    // Reset state and first accepted draw.
    fresh_reset();
    check("rst_ack",     32'(ack),         32'h0);
    check("rst_grant",   32'(grant),       32'h0);
    check("rst_busy",    32'(busy),        32'h0);
    check("rst_gen_ena", 32'(gen_ena),     32'h0);
    check("rst_data",    32'(rsp_data),    32'h0);
    check("rst_clamped", 32'(rsp_clamped), 32'h0);
    draw("first", 4'b0001, 32'h0000_00FF, 1'b0, d, a);
    check("first_value", 32'(d), 32'hDA);

    // One rejection, then accept.
    fresh_reset();
    draw("reject1", 4'b0001, 32'h0000_00D0, 1'b0, d, a);
    check("reject1_value", 32'(d), 32'hAC);

    // Clamp fallback on the MAX_RETRY=2 instance.
    fresh_reset();
    r2_req_max = 32'h0000_0050;
    r2_req     = 4'b0001;
    n       = 0;
    ena_cnt = 0;
    a       = '0;
    while (a == '0 && n < 200) begin
      @(posedge clk);
      @(negedge clk);
      n++;
      if (r2_gen_ena) ena_cnt++;
      a = r2_ack;
      d = r2_rsp_data;
      if (a != '0) check("clamp_flag", 32'(r2_rsp_clamped), 32'h1);
    end
    check("clamp_ack",     32'(a),       32'h1);
    check("clamp_data",    32'(d),       32'h50);
    check("clamp_shifts",  32'(ena_cnt), 32'd8);
    check("clamp_latency", 32'(n),       32'd11);
    r2_req = '0;

    // All requesters held: round-robin order and generator sequence.
    fresh_reset();
    draw("rr0", 4'b1111, 32'hFFFF_FFFF, 1'b0, d, a);
    check("rr0_value", 32'(d), 32'hDA);
    draw("rr1", 4'b1111, 32'hFFFF_FFFF, 1'b0, d, a);
    check("rr1_value", 32'(d), 32'hAC);
    check("rr1_owner", 32'(a), 32'h2);
    draw("rr2", 4'b1111, 32'hFFFF_FFFF, 1'b0, d, a);
    check("rr2_value", 32'(d), 32'hCB);
    check("rr2_owner", 32'(a), 32'h4);
    draw("rr3", 4'b1111, 32'hFFFF_FFFF, 1'b0, d, a);
    check("rr3_owner", 32'(a), 32'h8);
    draw("rr4", 4'b1111, 32'hFFFF_FFFF, 1'b0, d, a);
    check("rr4_owner", 32'(a), 32'h1);

    // Zero bound: immediate answer without touching the generator.
    draw("zero", 4'b0100, 32'hFF00_FFFF, 1'b0, d, a);
    check("zero_owner", 32'(a), 32'h4);
    check("zero_value", 32'(d), 32'h0);

    // Reset during the third STEP cycle aborts the draw.
    fresh_reset();
    draw("pre_abort", 4'b0001, 32'hFFFF_FFFF, 1'b0, d, a);
    req     = 4'b0011;
    req_max = 32'hFFFF_FFFF;
    seen    = '0;
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
      seen |= ack;
    end
    check("abort_busy_before",  32'(busy),  32'h1);
    check("abort_grant_before", 32'(grant), 32'h2);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    seen |= ack;
    check("abort_busy",    32'(busy),    32'h0);
    check("abort_grant",   32'(grant),   32'h0);
    check("abort_gen_ena", 32'(gen_ena), 32'h0);
    check("abort_no_ack",  32'(seen),    32'h0);
    rst = 1'b0;
    for (int s = 0; s < 3; s++) m_gen = lfsr_next(m_gen);
    m_last    = NREQ - 1;
    from_done = 1'b0;
    draw("post_abort", 4'b0011, 32'hFFFF_FFFF, 1'b0, d, a);
    check("post_abort_owner", 32'(a), 32'h1);

    // Randomized traffic: masks, bounds, drops and late bound changes.
    for (int i = 0; i < 30; i++) begin
      rr = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      rm = '0;
      for (int j = 0; j < NREQ; j++) begin
        case ($urandom_range(0, 7))
          0:       rm[8*j +: 8] = 8'h00;
          1:       rm[8*j +: 8] = 8'hFF;
          2, 3:    rm[8*j +: 8] = 8'($urandom_range(1, 15));
          default: rm[8*j +: 8] = 8'($urandom_range(0, 255));
        endcase
      end
      draw("rand", rr, rm, ($urandom_range(0, 3) == 0), d, a);
    end

    @(negedge clk);
    check("gen_start_eq_ena", 32'(start_bad), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
